// File: rtl/qspi_sram_master.sv
// QPI serial-SRAM master: one-byte read/write per request, 24-bit address,
// enters quad mode after reset with a single-bit command on SIO[0].
module qspi_sram_master #(
  parameter int         DUMMY_CYCLES   = 6,
  parameter int         CS_HIGH_CYCLES = 2,
  parameter logic [7:0] INIT_CMD       = 8'h35
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        BUS_REQ,
  input  logic        BUS_WE,
  input  logic [23:0] BUS_ADDR,
  input  logic [7:0]  BUS_WDATA,
  output logic [7:0]  BUS_RDATA,
  output logic        BUS_ACK,
  output logic        BUS_READY,
  output logic        QSPI_CS_N,
  output logic        QSPI_CS_E,
  output logic        QSPI_SCK,
  output logic        QSPI_SCK_E,
  output logic [3:0]  QSPI_SIO_O,
  output logic [3:0]  QSPI_SIO_E,
  input  logic [3:0]  QSPI_SIO_I
);

  typedef enum logic [3:0] {
    S_INIT_GAP, S_INIT_CMD, S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_WDATA, S_RDATA, S_GAP
  } state_t;

  state_t      r_state, w_state;
  logic [4:0]  r_cnt, w_cnt;
  logic        r_ph, w_ph;
  logic        r_sck, w_sck;
  logic        r_cs_n, w_cs_n;
  logic [3:0]  r_sio_o, w_sio_o;
  logic [3:0]  r_sio_e, w_sio_e;
  logic [7:0]  r_rdata, w_rdata;
  logic [3:0]  r_rhi, w_rhi;
  logic        r_ack, w_ack;
  logic        r_ready, w_ready;
  logic        w_accept;
  logic        w_last;
  logic        r_we;
  logic [23:0] r_addr;
  logic [7:0]  r_wdata;

  function automatic int seq_len(state_t s);
    case (s)
      S_INIT_CMD: return 8;
      S_ADDR:     return 6;
      S_DUMMY:    return DUMMY_CYCLES;
      default:    return 2;
    endcase
  endfunction

  function automatic state_t seq_next(state_t s, logic we);
    case (s)
      S_CMD:   return S_ADDR;
      S_ADDR:  return we ? S_WDATA : ((DUMMY_CYCLES > 0) ? S_DUMMY : S_RDATA);
      S_DUMMY: return S_RDATA;
      default: return S_GAP;
    endcase
  endfunction

  // Returns {SIO_E, SIO_O} for SCK cycle c of state s.
  function automatic logic [7:0] pin_drive(state_t s, logic [4:0] c, logic we,
                                           logic [23:0] a, logic [7:0] d);
    logic [7:0] cmd;
    cmd = we ? 8'h38 : 8'hEB;
    case (s)
      S_INIT_CMD: return {4'b0001, 3'b000, INIT_CMD[3'(7 - int'(c))]};
      S_CMD:      return {4'hF, c[0] ? cmd[3:0] : cmd[7:4]};
      S_ADDR:     return {4'hF, 4'(a >> (4 * (5 - int'(c))))};
      S_WDATA:    return {4'hF, c[0] ? d[3:0] : d[7:4]};
      default:    return 8'h00;
    endcase
  endfunction

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_ph     = r_ph;
    w_sck    = r_sck;
    w_cs_n   = r_cs_n;
    w_sio_o  = r_sio_o;
    w_sio_e  = r_sio_e;
    w_rdata  = r_rdata;
    w_rhi    = r_rhi;
    w_ack    = 1'b0;
    w_ready  = 1'b0;
    w_accept = 1'b0;
    w_last   = (int'(r_cnt) == seq_len(r_state) - 1);
    case (r_state)
      S_INIT_GAP, S_GAP: begin
        w_cnt = r_cnt + 5'd1;
        if (int'(r_cnt) >= CS_HIGH_CYCLES - 1) begin
          w_cnt = '0;
          if (r_state == S_INIT_GAP) begin
            w_state              = S_INIT_CMD;
            w_cs_n               = 1'b0;
            {w_sio_e, w_sio_o}   = pin_drive(S_INIT_CMD, 5'd0, r_we, r_addr, r_wdata);
          end else begin
            w_state = S_IDLE;
            w_ready = 1'b1;
          end
        end
      end
      S_IDLE: begin
        w_ready = 1'b1;
        if (BUS_REQ) begin
          w_accept           = 1'b1;
          w_ready            = 1'b0;
          w_state            = S_CMD;
          w_cnt              = '0;
          w_ph               = 1'b0;
          w_sck              = 1'b0;
          w_cs_n             = 1'b0;
          {w_sio_e, w_sio_o} = pin_drive(S_CMD, 5'd0, BUS_WE, BUS_ADDR, BUS_WDATA);
        end
      end
      default: begin
        if (!r_ph) begin
          w_sck = 1'b1;
          w_ph  = 1'b1;
        end else begin
          // End of phase 1: SRAM has driven SIO_I for a full SCK period.
          w_sck = 1'b0;
          w_ph  = 1'b0;
          if (r_state == S_RDATA) begin
            if (r_cnt == 5'd0) w_rhi = QSPI_SIO_I;
            else               w_rdata = {r_rhi, QSPI_SIO_I};
          end
          if (w_last) begin
            w_state = seq_next(r_state, r_we);
            w_cnt   = '0;
          end else begin
            w_cnt = r_cnt + 5'd1;
          end
          if (w_state == S_GAP) begin
            w_cs_n  = 1'b1;
            w_sio_e = 4'h0;
            w_sio_o = 4'h0;
            w_ack   = (r_state != S_INIT_CMD);
          end else begin
            {w_sio_e, w_sio_o} = pin_drive(w_state, w_cnt, r_we, r_addr, r_wdata);
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      r_state <= S_INIT_GAP;
      r_cnt   <= '0;
      r_ph    <= 1'b0;
      r_sck   <= 1'b0;
      r_cs_n  <= 1'b1;
      r_sio_o <= 4'h0;
      r_sio_e <= 4'h0;
      r_rdata <= 8'h00;
      r_ack   <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_ph    <= w_ph;
      r_sck   <= w_sck;
      r_cs_n  <= w_cs_n;
      r_sio_o <= w_sio_o;
      r_sio_e <= w_sio_e;
      r_rdata <= w_rdata;
      r_ack   <= w_ack;
      r_ready <= w_ready;
    end
  end

  // Request fields and the captured high nibble carry no reset.
  always_ff @(posedge CLK) begin
    r_rhi <= w_rhi;
    if (w_accept) begin
      r_we    <= BUS_WE;
      r_addr  <= BUS_ADDR;
      r_wdata <= BUS_WDATA;
    end
  end

  assign BUS_RDATA  = r_rdata;
  assign BUS_ACK    = r_ack;
  assign BUS_READY  = r_ready;
  assign QSPI_CS_N  = r_cs_n;
  assign QSPI_CS_E  = 1'b1;
  assign QSPI_SCK   = r_sck;
  assign QSPI_SCK_E = 1'b1;
  assign QSPI_SIO_O = r_sio_o;
  assign QSPI_SIO_E = r_sio_e;

endmodule
